sc_mux21_arbiter: RTL
=====================

Name: sc_mux21_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 2:1 data multiplexer path between two requesters.
- Each requester offers a valid/ready/last burst stream. The block grants one requester at a time, drives the mux select and routes accepted beats into a single registered output stage with valid/ready toward the downstream consumer.
- Caps each grant at MAX_BURST beats so neither requester can starve the other.

Parameters:
- NUMBER_DATAWIDTH, 8, width of each data bus.
- MAX_BURST, 4, maximum beats accepted per grant (must be >= 1). Beat counter width is $clog2(MAX_BURST+1).

Ports:
- SC_MUXARB21_CLOCK_50  input  1  system clock; all logic on the rising edge.
- SC_MUXARB21_RESET_InLow  input  1  reset, synchronous, active-low.
- SC_MUXARB21_req0Valid_In  input  1  requester 0 beat valid.
- SC_MUXARB21_req0Data_InBUS  input  NUMBER_DATAWIDTH  requester 0 data.
- SC_MUXARB21_req0Last_In  input  1  requester 0 final beat of burst.
- SC_MUXARB21_req0Ready_Out  output  1  requester 0 beat accepted when high with valid.
- SC_MUXARB21_req1Valid_In / req1Data_InBUS / req1Last_In / req1Ready_Out  same as requester 0, for requester 1.
- SC_MUXARB21_outValid_Out  output  1  output beat valid.
- SC_MUXARB21_outData_OutBUS  output  NUMBER_DATAWIDTH  output data (registered).
- SC_MUXARB21_outLast_Out  output  1  registered copy of the accepted beat's last flag.
- SC_MUXARB21_outReady_In  input  1  downstream ready.
- SC_MUXARB21_select_Out  output  1  mux select (0 = requester 0, 1 = requester 1).
- SC_MUXARB21_busy_Out  output  1  high when state is not IDLE.

Behaviour:
- Reset (RESET_InLow = 0 at a clock edge):
  - State = IDLE; outValid, outData, outLast, select, busy = 0.
  - Beat counter = 0; priority pointer = 0 (requester 0 preferred).
  - Both reqReady = 0. Any in-flight output beat is discarded. This applies equally during a burst.
- States:
  - IDLE: both reqReady = 0.
    - If only one reqValid is high, grant it.
    - If both are high, grant the requester named by the priority pointer.
    - On the next edge: state = GRANT0 or GRANT1, select = granted index, counter = 0.
    - If neither is valid, stay in IDLE.
  - GRANTn: reqReady_n = ~outValid | outReady (combinational); the other reqReady = 0.
    - Transfer occurs on an edge where reqValid_n & reqReady_n. At that edge: outData <= reqData_n through the mux, outLast <= reqLast_n, outValid <= 1, counter += 1.
- End of grant: on a transfer edge where reqLast_n = 1 or counter+1 == MAX_BURST.
  - Next state = IDLE, counter = 0, pointer = 1-n.
  - select holds its value until the next grant.
- Truncation: if a burst is cut by MAX_BURST, outLast carries the input's last flag (0). The requester resumes the rest of its burst on a later grant.
- Valid drop: if reqValid_n drops mid-grant, the grant is held and the block waits. The cycle counts as no transfer.
- Output stage:
  - outValid clears on an edge with outValid & outReady and no new transfer.
  - outData and outLast are held stable while outValid & ~outReady.
- Latency and throughput:
  - A beat accepted at edge k appears on the outputs from edge k to the next.
  - Within a grant, throughput is 1 beat per cycle.
  - Each grant costs exactly one IDLE arbitration cycle.
- Requests arriving in the same cycle a grant ends are arbitrated in the following IDLE cycle using the updated pointer.

Test Plan:
- Reset: hold RESET_InLow = 0 for 2 cycles with both reqValid = 1 -> all outputs 0, state IDLE. First grant goes to requester 0, with select = 1'b0 one edge after release.
- Single burst: req0 sends 0x11, 0x22, 0x33 (last on 0x33), outReady = 1 -> outData shows 0x11, 0x22, 0x33 on consecutive cycles, outLast = 1 with 0x33, then busy = 0.
- Contention: both request 2-beat bursts (req0 0xA0, 0xA1; req1 0xB0, 0xB1) -> order A0, A1, one bubble, B0, B1. Select goes 0 then 1, and the pointer returns to 0.
- MAX_BURST = 4 cap: req0 sends 6 beats 0x01..0x06 while req1 sends 0xC0 (last) -> 0x01..0x04, then 0xC0, then 0x05, 0x06. outLast = 0 on 0x04.
- Backpressure: outReady = 0 for 3 cycles mid-burst -> outData stays at the current beat, reqReady = 0, and no beat is lost or duplicated after outReady returns.
- Reset mid-burst: assert reset after 2 of 4 beats -> next edge outValid = 0, busy = 0, pointer = 0.

Source files
------------

// File: rtl/sc_mux21_arbiter.sv
// -----------------------------------------------------------------------------
// sc_mux21_arbiter
// Round-robin arbiter sharing one 2:1 data mux between two valid/ready/last
// burst requesters, feeding a single registered output stage. Each grant is
// capped at MAX_BURST beats and costs one IDLE arbitration cycle.
//
// Ports
//   SC_MUXARB21_CLOCK_50          in   clock, rising edge
//   SC_MUXARB21_RESET_InLow       in   synchronous active-low reset
//   SC_MUXARB21_req{0,1}Valid_In  in   requester beat valid
//   SC_MUXARB21_req{0,1}Data_InBUS in  requester data
//   SC_MUXARB21_req{0,1}Last_In   in   requester final beat of burst
//   SC_MUXARB21_req{0,1}Ready_Out out  requester beat accepted (combinational)
//   SC_MUXARB21_outValid_Out      out  output beat valid (registered)
//   SC_MUXARB21_outData_OutBUS    out  output data (registered)
//   SC_MUXARB21_outLast_Out       out  output last flag (registered)
//   SC_MUXARB21_outReady_In       in   downstream ready
//   SC_MUXARB21_select_Out        out  mux select, 0 = req0, 1 = req1
//   SC_MUXARB21_busy_Out          out  high while a grant is active
// -----------------------------------------------------------------------------
module sc_mux21_arbiter #(
    parameter int unsigned NUMBER_DATAWIDTH = 8,
    parameter int unsigned MAX_BURST        = 4
) (
    input  logic                        SC_MUXARB21_CLOCK_50,
    input  logic                        SC_MUXARB21_RESET_InLow,
    input  logic                        SC_MUXARB21_req0Valid_In,
    input  logic [NUMBER_DATAWIDTH-1:0] SC_MUXARB21_req0Data_InBUS,
    input  logic                        SC_MUXARB21_req0Last_In,
    output logic                        SC_MUXARB21_req0Ready_Out,
    input  logic                        SC_MUXARB21_req1Valid_In,
    input  logic [NUMBER_DATAWIDTH-1:0] SC_MUXARB21_req1Data_InBUS,
    input  logic                        SC_MUXARB21_req1Last_In,
    output logic                        SC_MUXARB21_req1Ready_Out,
    output logic                        SC_MUXARB21_outValid_Out,
    output logic [NUMBER_DATAWIDTH-1:0] SC_MUXARB21_outData_OutBUS,
    output logic                        SC_MUXARB21_outLast_Out,
    input  logic                        SC_MUXARB21_outReady_In,
    output logic                        SC_MUXARB21_select_Out,
    output logic                        SC_MUXARB21_busy_Out
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2
    } state_t;

    // Registered state
    state_t                      r_state;
    logic [CNT_W-1:0]            r_cnt;
    logic                        r_ptr;
    logic                        r_sel;
    logic                        r_out_valid;
    logic [NUMBER_DATAWIDTH-1:0] r_out_data;
    logic                        r_out_last;
    logic                        r_busy;

    // Next-state and combinational signals
    state_t                      w_state_nxt;
    logic [CNT_W-1:0]            w_cnt_nxt;
    logic                        w_ptr_nxt;
    logic                        w_sel_nxt;
    logic                        w_out_valid_nxt;
    logic [NUMBER_DATAWIDTH-1:0] w_out_data_nxt;
    logic                        w_out_last_nxt;
    logic                        w_rdy0;
    logic                        w_rdy1;
    logic                        w_xfer;
    logic                        w_stage_free;
    logic [NUMBER_DATAWIDTH-1:0] w_mux_data;
    logic                        w_mux_last;
    logic [CNT_W-1:0]            w_cnt_inc;
    logic                        w_cap;

    // Shared 2:1 data path, steered by the registered select
    assign w_mux_data   = r_sel ? SC_MUXARB21_req1Data_InBUS : SC_MUXARB21_req0Data_InBUS;
    assign w_mux_last   = r_sel ? SC_MUXARB21_req1Last_In    : SC_MUXARB21_req0Last_In;

    // Output register can take a beat when empty or draining this cycle
    assign w_stage_free = ~r_out_valid | SC_MUXARB21_outReady_In;

    // Counter never exceeds MAX_BURST within a grant, so CNT_W bits suffice
    assign w_cnt_inc    = r_cnt + CNT_W'(1);
    assign w_cap        = (32'(w_cnt_inc) == MAX_BURST);

    // Next-state, handshake and output-stage logic
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_ptr_nxt       = r_ptr;
        w_sel_nxt       = r_sel;
        w_out_valid_nxt = r_out_valid;
        w_out_data_nxt  = r_out_data;
        w_out_last_nxt  = r_out_last;
        w_rdy0          = 1'b0;
        w_rdy1          = 1'b0;
        w_xfer          = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // Lone requester wins; on contention the pointer decides
                if (SC_MUXARB21_req0Valid_In && (!SC_MUXARB21_req1Valid_In || !r_ptr)) begin
                    w_state_nxt = ST_GRANT0;
                    w_sel_nxt   = 1'b0;
                    w_cnt_nxt   = '0;
                end else if (SC_MUXARB21_req1Valid_In) begin
                    w_state_nxt = ST_GRANT1;
                    w_sel_nxt   = 1'b1;
                    w_cnt_nxt   = '0;
                end
            end
            ST_GRANT0: begin
                w_rdy0 = w_stage_free;
                w_xfer = SC_MUXARB21_req0Valid_In & w_stage_free;
            end
            ST_GRANT1: begin
                w_rdy1 = w_stage_free;
                w_xfer = SC_MUXARB21_req1Valid_In & w_stage_free;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_xfer) begin
            w_out_valid_nxt = 1'b1;
            w_out_data_nxt  = w_mux_data;
            w_out_last_nxt  = w_mux_last;
            w_cnt_nxt       = w_cnt_inc;
            // Grant ends on the burst's last beat or when the cap is hit
            if (w_mux_last || w_cap) begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                w_ptr_nxt   = (r_state == ST_GRANT0);
            end
        end else if (r_out_valid && SC_MUXARB21_outReady_In) begin
            w_out_valid_nxt = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge SC_MUXARB21_CLOCK_50) begin
        if (!SC_MUXARB21_RESET_InLow) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_ptr       <= 1'b0;
            r_sel       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_ptr       <= w_ptr_nxt;
            r_sel       <= w_sel_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_last  <= w_out_last_nxt;
            r_busy      <= (w_state_nxt != ST_IDLE);
        end
    end

    assign SC_MUXARB21_req0Ready_Out  = w_rdy0;
    assign SC_MUXARB21_req1Ready_Out  = w_rdy1;
    assign SC_MUXARB21_outValid_Out   = r_out_valid;
    assign SC_MUXARB21_outData_OutBUS = r_out_data;
    assign SC_MUXARB21_outLast_Out    = r_out_last;
    assign SC_MUXARB21_select_Out     = r_sel;
    assign SC_MUXARB21_busy_Out       = r_busy;

endmodule
